// File: rtl/tree_node_fanin_merger_if.sv
`default_nettype none
// ============================================================================
// Module   : tree_node_fanin_merger_if
// Brief    : Child-side and upstream-side handshake bundle of the fan-in merger.
// Revision : 1.0 - initial release
// ============================================================================
interface tree_node_fanin_merger_if #(
    parameter int NUM_CHILD  = 5,
    parameter int DATA_W     = 8,
    parameter int ID_W       = 3,
    parameter int FIFO_DEPTH = 4
);
    logic [NUM_CHILD-1:0]              child_valid;
    logic [NUM_CHILD*DATA_W-1:0]       child_data;
    logic [NUM_CHILD-1:0]              child_ready;
    logic                              up_valid;
    logic [ID_W+DATA_W-1:0]            up_data;
    logic                              up_ready;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy;

    // master drives the children and the parent's ready; slave is the merger
    modport master (
        output child_valid, child_data, up_ready,
        input  child_ready, up_valid, up_data, occupancy
    );

    modport slave (
        input  child_valid, child_data, up_ready,
        output child_ready, up_valid, up_data, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/tree_node_fanin_merger.sv
`default_nettype none
// ============================================================================
// Module   : tree_node_fanin_merger
// Brief    : Round-robin merge of child streams into one tagged upstream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tree_node_fanin_merger #(
    parameter int NUM_CHILD  = 5,
    parameter int DATA_W     = 8,
    parameter int ID_W       = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    tree_node_fanin_merger_if.slave bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = ID_W + DATA_W;

    logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [OCC_W-1:0]     r_occ;
    logic [ID_W-1:0]      r_last_grant;

    logic [DATA_W-1:0]    w_child_word [NUM_CHILD];
    logic                 w_full;
    logic                 w_grant_vld;
    logic [ID_W-1:0]      w_grant_idx;
    logic [NUM_CHILD-1:0] w_ready;
    logic                 w_push;
    logic                 w_pop;

    for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_unpack
        assign w_child_word[gi] = bus.child_data[gi*DATA_W +: DATA_W];
    end

    assign w_full = (r_occ == OCC_W'(FIFO_DEPTH));

    // Search starts one past the last winner so every valid child is served in turn.
    always_comb begin
        int idx_int;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        idx_int     = 0;
        for (int k = 1; k <= NUM_CHILD; k++) begin
            idx_int = (int'(r_last_grant) + k) % NUM_CHILD;
            if (!w_grant_vld && bus.child_valid[idx_int[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = idx_int[ID_W-1:0];
            end
        end
        // A full FIFO blocks refill even when the head is popped this cycle.
        if (rst || w_full) begin
            w_grant_vld = 1'b0;
        end
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            w_ready[i] = w_grant_vld && (w_grant_idx == ID_W'(i));
        end
    end

    assign w_push = w_grant_vld;
    assign w_pop  = (r_occ != '0) && bus.up_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_last_grant <= ID_W'(NUM_CHILD - 1);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_grant_idx, w_child_word[w_grant_idx]};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_last_grant    <= w_grant_idx;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign bus.child_ready = w_ready;
    assign bus.up_valid    = (r_occ != '0);
    assign bus.up_data     = r_mem[r_rd_ptr];
    assign bus.occupancy   = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_tree_node_fanin_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_tree_node_fanin_merger
// Brief    : Randomized self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tree_node_fanin_merger;
    localparam int NC    = 5;
    localparam int DW    = 8;
    localparam int IW    = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    tree_node_fanin_merger_if #(.NUM_CHILD(NC), .DATA_W(DW), .ID_W(IW), .FIFO_DEPTH(DEPTH)) bus ();

    tree_node_fanin_merger #(.NUM_CHILD(NC), .DATA_W(DW), .ID_W(IW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: ordered queue of tagged words plus the last winner.
    logic [IW+DW-1:0] m_q [$];
    int               m_last = NC - 1;
    int               m_pops = 0;

    function automatic int model_grant();
        if (rst || m_q.size() >= DEPTH) return -1;
        for (int k = 1; k <= NC; k++) begin
            int idx = (m_last + k) % NC;
            if (bus.child_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NC-1:0] model_ready();
        logic [NC-1:0] r = '0;
        int g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        int            g;
        bit            pop;
        logic [DW-1:0] d;
        g   = model_grant();
        pop = (m_q.size() != 0) && bus.up_ready;
        d   = (g >= 0) ? bus.child_data[g*DW +: DW] : '0;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_last = NC - 1;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            if (g >= 0) begin
                m_q.push_back({IW'(g), d});
                m_last = g;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.child_valid = '1;
        bus.child_data  = '0;
        bus.up_ready    = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.child_ready !== 5'b00000) begin
            errors++; $display("FAIL reset_ready got=%b exp=00000", bus.child_ready);
        end
        checks++;
        if (bus.up_valid !== 1'b0 || bus.occupancy !== 3'd0) begin
            errors++; $display("FAIL reset_state up_valid=%b occ=%0d exp 0/0", bus.up_valid, bus.occupancy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.child_ready !== 5'b00001) begin
            errors++; $display("FAIL reset_first_grant got=%b exp=00001", bus.child_ready);
        end
        bus.child_valid = '0;
        tick();
    endtask

    task automatic test_single();
        bus.child_valid = 5'b00100;
        bus.child_data[2*DW +: DW] = 8'hA5;
        bus.up_ready = 1'b1;
        #1;
        checks++;
        if (bus.child_ready !== 5'b00100) begin
            errors++; $display("FAIL single_ready got=%b exp=00100", bus.child_ready);
        end
        tick();
        bus.child_valid = '0;
        #1;
        checks++;
        if (bus.up_valid !== 1'b1 || bus.up_data !== 11'h2A5 || bus.occupancy !== 3'd1) begin
            errors++; $display("FAIL single_out up_valid=%b data=%h occ=%0d exp 1/2a5/1",
                               bus.up_valid, bus.up_data, bus.occupancy);
        end
        tick();
        checks++;
        if (bus.up_valid !== 1'b0 || bus.occupancy !== 3'd0) begin
            errors++; $display("FAIL single_drain up_valid=%b occ=%0d exp 0/0", bus.up_valid, bus.occupancy);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        bus.up_ready = 1'b1;
        for (int i = 0; i < NC; i++) bus.child_data[i*DW +: DW] = DW'($urandom);
        bus.child_valid = '1;
        for (int c = 0; c < 15; c++) begin
            logic [NC-1:0] exp_r;
            int            g;
            #1;
            exp_r = '0;
            exp_r[c % NC] = 1'b1;
            checks++;
            if (bus.child_ready !== exp_r) begin
                errors++; $display("FAIL fair_grant cycle=%0d got=%b exp=%b", c, bus.child_ready, exp_r);
            end
            if (c > 0) begin
                checks++;
                if (bus.up_valid !== 1'b1 || bus.up_data !== m_q[0] || bus.up_data[DW +: IW] !== IW'((c - 1) % NC)) begin
                    errors++; $display("FAIL fair_out cycle=%0d valid=%b data=%h exp=%h", c, bus.up_valid, bus.up_data, m_q[0]);
                end
            end
            g = model_grant();
            tick();
            if (g >= 0) bus.child_data[g*DW +: DW] = DW'($urandom);
        end
        bus.child_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.up_ready    = 1'b0;
        bus.child_valid = '1;
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            checks++;
            if (bus.child_ready !== 5'(1 << c)) begin
                errors++; $display("FAIL bp_fill cycle=%0d got=%b exp=%b", c, bus.child_ready, 5'(1 << c));
            end
            tick();
        end
        checks++;
        if (bus.occupancy !== 3'd4 || bus.child_ready !== 5'b00000) begin
            errors++; $display("FAIL bp_full occ=%0d ready=%b exp 4/00000", bus.occupancy, bus.child_ready);
        end
        bus.up_ready = 1'b1;
        #1;
        checks++;
        if (bus.child_ready !== 5'b00000) begin
            errors++; $display("FAIL bp_no_refill got=%b exp=00000", bus.child_ready);
        end
        for (int p = 0; p < 5; p++) begin
            checks++;
            if (bus.up_valid !== 1'b1 || bus.up_data[DW +: IW] !== IW'(p) || bus.up_data !== m_q[0]) begin
                errors++; $display("FAIL bp_pop idx=%0d valid=%b data=%h exp_tag=%0d", p, bus.up_valid, bus.up_data, p);
            end
            tick();
            if (p == 0) begin
                checks++;
                if (bus.child_ready !== 5'b10000) begin
                    errors++; $display("FAIL bp_resume got=%b exp=10000", bus.child_ready);
                end
            end
        end
        bus.child_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.up_ready    = 1'b0;
        bus.child_valid = '1;
        repeat (3) tick();
        checks++;
        if (bus.occupancy !== 3'd3) begin
            errors++; $display("FAIL mid_fill occ=%0d exp=3", bus.occupancy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.occupancy !== 3'd0 || bus.up_valid !== 1'b0 || bus.child_ready !== 5'b00001) begin
            errors++; $display("FAIL mid_reset occ=%0d valid=%b ready=%b exp 0/0/00001",
                               bus.occupancy, bus.up_valid, bus.child_ready);
        end
        bus.child_valid = '0;
        tick();
    endtask

    task automatic test_wrap_hold();
        int               issued = 0;
        int               pops0;
        bit               done = 0;
        logic             prev_hold = 1'b0;
        logic [IW+DW-1:0] prev_data = '0;
        do_reset();
        pops0 = m_pops;
        for (int c = 0; c < 400 && !done; c++) begin
            int g;
            for (int i = 0; i < NC; i++) begin
                if (!bus.child_valid[i] && issued < 10 && $urandom_range(1, 0) == 1) begin
                    bus.child_valid[i] = 1'b1;
                    bus.child_data[i*DW +: DW] = DW'($urandom);
                    issued++;
                end
            end
            bus.up_ready = 1'($urandom_range(1, 0));
            #1;
            checks++;
            if (bus.child_ready !== model_ready() || bus.occupancy !== 3'(m_q.size()) || bus.occupancy > 3'd4) begin
                errors++; $display("FAIL wrap_ctrl cycle=%0d ready=%b exp=%b occ=%0d exp=%0d",
                                   c, bus.child_ready, model_ready(), bus.occupancy, m_q.size());
            end
            checks++;
            if (bus.up_valid !== (m_q.size() != 0) || (m_q.size() != 0 && bus.up_data !== m_q[0])) begin
                errors++; $display("FAIL wrap_out cycle=%0d valid=%b data=%h exp_valid=%0d", c, bus.up_valid, bus.up_data, m_q.size() != 0);
            end
            if (prev_hold) begin
                checks++;
                if (bus.up_data !== prev_data) begin
                    errors++; $display("FAIL wrap_hold cycle=%0d data=%h exp=%h", c, bus.up_data, prev_data);
                end
            end
            prev_hold = bus.up_valid && !bus.up_ready;
            prev_data = bus.up_data;
            g = model_grant();
            tick();
            if (g >= 0) bus.child_valid[g] = 1'b0;
            done = (issued == 10) && (bus.child_valid == '0) && (m_q.size() == 0);
        end
        checks++;
        if (!done || (m_pops - pops0) != 10) begin
            errors++; $display("FAIL wrap_complete done=%0d popped=%0d exp=10", done, m_pops - pops0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_wrap_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exceeded simulation time limit");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
